// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset PC and the fetch-stage state encoding.
package cpu_pkg;

  localparam int XLEN = 19;

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(0);

  // FETCH: may issue a request; WAIT: one request outstanding;
  // FLUSH: outstanding response belongs to a squashed path and is dropped.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus and the decode-facing instruction stream.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int XLEN = cpu_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction queue: registered storage, head read straight from storage
// (no fall-through), synchronous clear with priority over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding instruction-memory requests, returned words
// queued with their PCs for decode, redirect flushes queued and in-flight work.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] progcnt,
  input  logic            redirect,
  fetch_unit_if.master    bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic [CW-1:0]     count;
  logic              empty;
  logic [2*XLEN-1:0] head;
  logic              req, grant, push, pop, valid;

  // A request is only issued in FETCH, so count < DEPTH leaves one slot for its response.
  assign req   = !reset && (state_q == FETCH) && !redirect && (count < CW'(DEPTH));
  assign grant = req && bus.imem_gnt;
  assign push  = (state_q == WAIT) && bus.imem_rvalid && !redirect;
  assign valid = !empty && !redirect;
  assign pop   = valid && bus.inst_ready;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_in;
  assign bus.inst_valid = valid;
  assign bus.inst_data  = empty ? '0 : head[2*XLEN-1:XLEN];
  assign bus.inst_pc    = empty ? '0 : head[XLEN-1:0];

  // PC advances only on an accepted fetch; wraps modulo 2^XLEN.
  assign progcnt = grant ? (pc_in + XLEN'(1)) : pc_in;

  // Next-state logic: a response arriving together with a redirect is consumed, not flushed.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      FETCH: begin
        if (grant) begin
          state_d  = WAIT;
          req_pc_d = pc_in;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid)  state_d = FETCH;
        else if (redirect)    state_d = FLUSH;
      end
      FLUSH: begin
        if (bus.imem_rvalid)  state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State and request-PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({bus.imem_rdata, req_pc_q}),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC (nextpc), issues single-outstanding requests to instruction memory, and buffers returned words with their PCs in a small queue for decode.
- Drives progcnt back to the program counter, so the PC advances only when a fetch is accepted.
- Flushes all buffered and in-flight work on a control-flow redirect (branch/jump/call/ret).

Parameters:
- DEPTH, 4, instruction queue entries; power of 2, >= 2
- XLEN, 19, address and instruction width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pc_in  in  XLEN  current PC (nextpc from program counter)
- progcnt  out  XLEN  sequential next PC returned to program counter
- redirect  in  1  OR of branch/jump/call/ret this cycle; PC loads its target at the end of this cycle
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address, equals pc_in
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; exactly one per granted request, >= 1 cycle after grant
- imem_rdata  in  XLEN  instruction word
- inst_valid  out  1  queue head valid to decode
- inst_data  out  XLEN  queue head instruction
- inst_pc  out  XLEN  PC of queue head
- inst_ready  in  1  decode accepts head

Behaviour:
- Reset: state=FETCH, queue empty, count=0, no request in flight. Outputs: imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
- FSM states:
  - FETCH: imem_req = !redirect && (count < DEPTH). On imem_req && imem_gnt, latch the address as req_pc and go to WAIT.
  - WAIT: imem_req=0. When imem_rvalid is seen, push {imem_rdata, req_pc} and go to FETCH. If redirect is seen, go to FLUSH.
  - FLUSH: imem_req=0. Discard the next imem_rvalid, then go to FETCH. If imem_rvalid and redirect occur in the same cycle, the response is discarded and the next state is FETCH.
- Queue accounting:
  - Space check counts the in-flight slot: a request is allowed only when count < DEPTH, and the reserved slot guarantees the response always has room.
  - Push and pop in the same cycle are legal; count is unchanged.
- progcnt (combinational):
  - pc_in + 1 (mod 2^19; 0x7FFFF wraps to 0x00000) when imem_req && imem_gnt.
  - Otherwise pc_in, so the PC holds.
- Latency: grant in cycle t, rvalid in cycle t+k. The entry is visible on inst_valid in cycle t+k+1. Minimum PC-to-decode latency is 2 cycles.
- Redirect (cycle t):
  - Queue cleared and count=0 at the end of t.
  - inst_valid is forced 0 during t, so no handshake occurs.
  - A push in t is dropped.
  - An in-flight request is tracked via FLUSH.
  - From t+1 fetching resumes from the new pc_in.
  - Redirect has priority over push, pop and grant.
- imem_rvalid while in FETCH (no outstanding request) is ignored; this covers responses arriving after reset mid-operation.
- Reset mid-operation: all state is cleared immediately (async). Queue contents are lost and no request is outstanding afterwards.
- inst_data and inst_pc are stable while inst_valid && !inst_ready.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=19
  - fetch state enum {FETCH, WAIT, FLUSH}
  - RESET_PC=19'h0
- Sub-module fetch_fifo (DEPTH x 2*XLEN):
  - synchronous push/pop/clear, count output, async reset
  - head data registered in storage; no fall-through

Test Plan:
- Reset, then pc_in=0, gnt=1 every cycle, rvalid 1 cycle after grant, ready=1 -> progcnt=1 on each grant; decode sees PCs 0,1,2,... at one instruction per 2 cycles.
- inst_ready=0, DEPTH=4, zero-wait memory -> exactly 4 grants then imem_req=0 and progcnt==pc_in (hold); assert ready -> fetching resumes at PC 4.
- Request granted at pc 0x10, redirect 1 cycle later with PC target 0x40, rvalid returns 0x1ABCD 3 cycles later -> 0x1ABCD never reaches decode; next inst_pc=0x40.
- Queue holds 3 entries, redirect asserted with inst_ready=1 -> inst_valid=0 that cycle, count=0 next cycle, no pop recorded.
- pc_in=0x7FFFF granted -> progcnt=0x00000; inst_pc=0x7FFFF delivered.
- Assert reset while in WAIT, deassert, then a stale rvalid arrives -> ignored; inst_valid stays 0 until a new grant and response.
